// File: rtl/l1_mau_rr.sv
// Round-robin L1 memory access unit: arbitrates NCH requesters onto one Wishbone B4
// pipelined master, keeping an in-order outstanding FIFO between issue and response.
module l1_mau_rr #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LW  = 256,
  parameter int unsigned OD  = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NCH-1:0]        req_val,
  input  logic [NCH-1:0]        req_we,
  input  logic [NCH-1:0]        req_nc,
  input  logic [NCH*AW-1:0]     req_addr,
  input  logic [NCH*DW-1:0]     req_wdata,
  input  logic [NCH*(DW/8)-1:0] req_be,
  output logic [NCH-1:0]        req_ack,
  output logic [LW-1:0]         ack_data,
  output logic                  ack_err,
  output logic                  ack_we,
  output logic                  ack_nc,
  input  logic [DW-1:0]         wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_stall_i,
  output logic [DW-1:0]         wb_dat_o,
  output logic [AW-1:0]         wb_adr_o,
  output logic [DW/8-1:0]       wb_sel_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o
);

  localparam int unsigned BW    = DW / 8;
  localparam int unsigned BEATS = LW / DW;
  localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW    = $clog2(BEATS) + 1;
  localparam int unsigned AI    = $clog2(OD);
  localparam int unsigned PW    = AI + 1;
  localparam int unsigned LOFF  = $clog2(LW / 8);
  localparam int unsigned BOFF  = $clog2(BW);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  // Outstanding FIFO storage
  logic [CHW-1:0] f_ch    [OD];
  logic           f_we    [OD];
  logic           f_nc    [OD];
  logic           f_multi [OD];
  logic [AW-1:0]  f_addr  [OD];
  logic [BW-1:0]  f_be    [OD];
  logic [DW-1:0]  f_wdata [OD];

  // wr: next push, iss: next entry to issue, rd: head awaiting responses
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  iss_ptr_q, iss_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  count;
  logic           full;

  logic [CHW-1:0] ptr_q, ptr_d;
  logic [NCH-1:0] inflight_q, inflight_d;
  logic [NCH-1:0] elig;
  logic           gnt_val;
  logic [CHW-1:0] gnt_ch;
  logic [CHW:0]   rot_sum;
  logic [CHW-1:0] rot_ch;

  state_e         state_q, state_d;
  logic [CW-1:0]  iss_beat_q, iss_beat_d;
  logic [AI-1:0]  cur;
  logic           iss_last;
  logic [AW-1:0]  line_base;

  logic [CW-1:0]  rsp_beat_q, rsp_beat_d;
  logic           err_q, err_d;
  logic [AI-1:0]  head;
  logic           rsp;
  logic           rsp_last;
  logic           pop;
  logic [LW-1:0]  ack_data_q, ack_data_d;
  logic [NCH-1:0] req_ack_q, req_ack_d;
  logic           ack_err_q, ack_err_d;
  logic           ack_we_q, ack_we_d;
  logic           ack_nc_q, ack_nc_d;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PW'(OD));
  assign elig  = req_val & ~inflight_q & {NCH{~full}};

  // Arbiter: walk offsets from the pointer downwards so the nearest eligible channel wins
  always_comb begin
    gnt_val = 1'b0;
    gnt_ch  = '0;
    rot_sum = '0;
    rot_ch  = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      rot_sum = {1'b0, ptr_q} + (CHW + 1)'(j);
      if (rot_sum >= (CHW + 1)'(NCH)) rot_sum = rot_sum - (CHW + 1)'(NCH);
      rot_ch = rot_sum[CHW-1:0];
      if (elig[rot_ch]) begin
        gnt_val = 1'b1;
        gnt_ch  = rot_ch;
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    inflight_d = inflight_q & ~req_ack_q;
    wr_ptr_d   = wr_ptr_q;
    if (gnt_val) begin
      ptr_d              = (gnt_ch == CHW'(NCH - 1)) ? '0 : gnt_ch + CHW'(1);
      inflight_d[gnt_ch] = 1'b1;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (gnt_val) begin
      f_ch[wr_ptr_q[AI-1:0]]    <= gnt_ch;
      f_we[wr_ptr_q[AI-1:0]]    <= req_we[gnt_ch];
      f_nc[wr_ptr_q[AI-1:0]]    <= req_nc[gnt_ch];
      f_multi[wr_ptr_q[AI-1:0]] <= ~req_we[gnt_ch] & ~req_nc[gnt_ch];
      f_addr[wr_ptr_q[AI-1:0]]  <= req_addr[gnt_ch*AW +: AW];
      f_be[wr_ptr_q[AI-1:0]]    <= req_be[gnt_ch*BW +: BW];
      f_wdata[wr_ptr_q[AI-1:0]] <= req_wdata[gnt_ch*DW +: DW];
    end
  end

  // Issue side
  assign cur       = iss_ptr_q[AI-1:0];
  assign iss_last  = ~f_multi[cur] | (iss_beat_q == CW'(BEATS - 1));
  assign line_base = {f_addr[cur][AW-1:LOFF], {LOFF{1'b0}}};

  always_comb begin
    state_d    = state_q;
    iss_ptr_d  = iss_ptr_q;
    iss_beat_d = iss_beat_q;
    unique case (state_q)
      StIdle: begin
        if (iss_ptr_q != wr_ptr_q) state_d = StIssue;
      end
      StIssue: begin
        if (!wb_stall_i) begin
          if (iss_last) begin
            iss_beat_d = '0;
            iss_ptr_d  = iss_ptr_q + PW'(1);
            if (iss_ptr_d == wr_ptr_q) state_d = StIdle;
          end else begin
            iss_beat_d = iss_beat_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_stb_o = (state_q == StIssue);
    wb_we_o  = wb_stb_o & f_we[cur];
    wb_adr_o = '0;
    wb_sel_o = '0;
    wb_dat_o = '0;
    if (wb_stb_o) begin
      wb_adr_o = f_multi[cur] ? line_base + (AW'(iss_beat_q) << BOFF) : f_addr[cur];
      wb_sel_o = f_multi[cur] ? {BW{1'b1}} : f_be[cur];
      if (f_we[cur]) wb_dat_o = f_wdata[cur];
    end
  end

  assign wb_cyc_o = (count != '0);

  // Response side
  assign head     = rd_ptr_q[AI-1:0];
  assign rsp      = (wb_ack_i | wb_err_i) & (count != '0);
  assign rsp_last = ~f_multi[head] | (rsp_beat_q == CW'(BEATS - 1));

  always_comb begin
    rsp_beat_d = rsp_beat_q;
    err_d      = err_q;
    ack_data_d = ack_data_q;
    req_ack_d  = '0;
    ack_err_d  = ack_err_q;
    ack_we_d   = ack_we_q;
    ack_nc_d   = ack_nc_q;
    pop        = 1'b0;
    if (rsp) begin
      ack_data_d = f_multi[head] ? {wb_dat_i, ack_data_q[LW-1:DW]} : LW'(wb_dat_i);
      if (rsp_last) begin
        pop                    = 1'b1;
        rsp_beat_d             = '0;
        err_d                  = 1'b0;
        req_ack_d[f_ch[head]]  = 1'b1;
        ack_err_d              = err_q | wb_err_i;
        ack_we_d               = f_we[head];
        ack_nc_d               = f_nc[head];
      end else begin
        rsp_beat_d = rsp_beat_q + CW'(1);
        err_d      = err_q | wb_err_i;
      end
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      iss_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      ptr_q      <= '0;
      inflight_q <= '0;
      state_q    <= StIdle;
      iss_beat_q <= '0;
      rsp_beat_q <= '0;
      err_q      <= 1'b0;
      ack_data_q <= '0;
      req_ack_q  <= '0;
      ack_err_q  <= 1'b0;
      ack_we_q   <= 1'b0;
      ack_nc_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      iss_ptr_q  <= iss_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
      iss_beat_q <= iss_beat_d;
      rsp_beat_q <= rsp_beat_d;
      err_q      <= err_d;
      ack_data_q <= ack_data_d;
      req_ack_q  <= req_ack_d;
      ack_err_q  <= ack_err_d;
      ack_we_q   <= ack_we_d;
      ack_nc_q   <= ack_nc_d;
    end
  end

  assign req_ack  = req_ack_q;
  assign ack_data = ack_data_q;
  assign ack_err  = ack_err_q;
  assign ack_we   = ack_we_q;
  assign ack_nc   = ack_nc_q;

endmodule
